// File: rtl/lockstep_pkg.sv
// Shared types and helpers for the commit-stream lockstep checker.
package lockstep_pkg;

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} lockstep_state_t;

  // Bits needed to index n entries; never narrower than one bit.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Increment v, holding at the largest value that fits in w bits.
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
    logic [63:0] max_v;
    max_v = (64'd1 << w) - 64'd1;
    return (v == max_v) ? v : v + 64'd1;
  endfunction

endpackage

// File: rtl/lockstep_fifo.sv
// Synchronous FIFO with extra-MSB pointers; head data is read combinationally.
module lockstep_fifo import lockstep_pkg::*; #(
  parameter int unsigned DATA_SIZE = 32,
  parameter int unsigned DEPTH     = 8
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 CLEAR,
  input  logic                 push,
  input  logic                 pop,
  input  logic [DATA_SIZE-1:0] wdata,
  output logic [DATA_SIZE-1:0] rdata,
  output logic                 empty,
  output logic                 full
);

  localparam int unsigned AW = ptr_width(DEPTH);

  logic [DATA_SIZE-1:0] mem [DEPTH];
  logic [AW:0]          wptr;
  logic [AW:0]          rptr;
  logic                 do_pop;
  logic                 do_push;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A concurrent pop frees the slot, so a full FIFO still accepts the push.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr[AW-1:0]];

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wptr <= '0;
      rptr <= '0;
    end else if (CLEAR) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/commit_lockstep_checker.sv
// Buffers the pipelined and golden commit streams and compares them in order,
// halting on the first mismatch, overflow or stream-imbalance timeout.
module commit_lockstep_checker import lockstep_pkg::*; #(
  parameter int unsigned DATA_SIZE = 32,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned TIMEOUT   = 64,
  parameter int unsigned CNT_SIZE  = 16
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 CLEAR,
  input  logic                 dut_valid,
  input  logic [DATA_SIZE-1:0] dut_data,
  input  logic                 gold_valid,
  input  logic [DATA_SIZE-1:0] gold_data,
  output logic [CNT_SIZE-1:0]  match_count,
  output logic [CNT_SIZE-1:0]  mismatch_count,
  output logic [DATA_SIZE-1:0] first_dut,
  output logic [DATA_SIZE-1:0] first_gold,
  output logic                 error,
  output logic                 overflow,
  output logic                 timeout,
  output logic                 halted
);

  localparam int unsigned TW = ptr_width(TIMEOUT + 1);

  lockstep_state_t      state;
  lockstep_state_t      state_next;
  logic                 run_c;
  logic                 dut_push_c, gold_push_c, pop_c, eq_c, tmo_inc_c;
  logic                 set_ovf_c, set_tmo_c, set_mis_c;
  logic                 dut_empty, dut_full, gold_empty, gold_full;
  logic [DATA_SIZE-1:0] dut_head, gold_head;
  logic                 mismatch_seen;
  logic [TW-1:0]        tmo_cnt;

  lockstep_fifo #(.DATA_SIZE(DATA_SIZE), .DEPTH(DEPTH)) u_dut_fifo (
    .CLK(CLK), .RESET_N(RESET_N), .CLEAR(CLEAR), .push(dut_push_c), .pop(pop_c),
    .wdata(dut_data), .rdata(dut_head), .empty(dut_empty), .full(dut_full)
  );

  lockstep_fifo #(.DATA_SIZE(DATA_SIZE), .DEPTH(DEPTH)) u_gold_fifo (
    .CLK(CLK), .RESET_N(RESET_N), .CLEAR(CLEAR), .push(gold_push_c), .pop(pop_c),
    .wdata(gold_data), .rdata(gold_head), .empty(gold_empty), .full(gold_full)
  );

  // Compare, overflow and timeout conditions; everything is frozen in HALT.
  assign dut_push_c  = run_c && dut_valid;
  assign gold_push_c = run_c && gold_valid;
  assign pop_c       = run_c && !dut_empty && !gold_empty;
  assign eq_c        = (dut_head == gold_head);
  assign tmo_inc_c   = run_c && (dut_empty != gold_empty) && !pop_c;
  assign set_ovf_c   = !pop_c && ((dut_push_c && dut_full) || (gold_push_c && gold_full));
  assign set_tmo_c   = tmo_inc_c && (tmo_cnt == TW'(TIMEOUT - 1)) && !timeout;
  assign set_mis_c   = pop_c && !eq_c && !mismatch_seen;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= RUN;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (set_ovf_c || set_tmo_c || set_mis_c) state_next = HALT;
      HALT:    state_next = HALT;
      default: state_next = RUN;
    endcase
    if (CLEAR) state_next = RUN;
  end

  always_comb begin
    run_c  = 1'b0;
    halted = 1'b0;
    case (state)
      RUN:     run_c  = 1'b1;
      HALT:    halted = 1'b1;
      default: run_c  = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      match_count    <= '0;
      mismatch_count <= '0;
      first_dut      <= '0;
      first_gold     <= '0;
      mismatch_seen  <= 1'b0;
      overflow       <= 1'b0;
      timeout        <= 1'b0;
      error          <= 1'b0;
      tmo_cnt        <= '0;
    end else if (CLEAR) begin
      match_count    <= '0;
      mismatch_count <= '0;
      first_dut      <= '0;
      first_gold     <= '0;
      mismatch_seen  <= 1'b0;
      overflow       <= 1'b0;
      timeout        <= 1'b0;
      error          <= 1'b0;
      tmo_cnt        <= '0;
    end else if (run_c) begin
      if (pop_c) begin
        if (eq_c) match_count    <= CNT_SIZE'(sat_inc(64'(match_count), CNT_SIZE));
        else      mismatch_count <= CNT_SIZE'(sat_inc(64'(mismatch_count), CNT_SIZE));
      end
      if (set_mis_c) begin
        first_dut     <= dut_head;
        first_gold    <= gold_head;
        mismatch_seen <= 1'b1;
      end
      if (pop_c || (dut_empty && gold_empty)) tmo_cnt <= '0;
      else if (tmo_inc_c && tmo_cnt != TW'(TIMEOUT)) tmo_cnt <= tmo_cnt + TW'(1);
      if (set_ovf_c) overflow <= 1'b1;
      if (set_tmo_c) timeout  <= 1'b1;
      if (set_ovf_c || set_tmo_c || set_mis_c) error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_commit_lockstep_checker.sv
// Directed scenario bench for commit_lockstep_checker.
module tb_commit_lockstep_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        dut_valid, gold_valid;
  logic [31:0] dut_data, gold_data;
  logic [15:0] match_count, mismatch_count;
  logic [31:0] first_dut, first_gold;
  logic        error, overflow, timeout, halted;

  int checks = 0;
  int errors = 0;

  commit_lockstep_checker #(.DATA_SIZE(32), .DEPTH(8), .TIMEOUT(64), .CNT_SIZE(16)) dut (
    .CLK(clk), .RESET_N(rst_n), .CLEAR(clear),
    .dut_valid(dut_valid), .dut_data(dut_data),
    .gold_valid(gold_valid), .gold_data(gold_data),
    .match_count(match_count), .mismatch_count(mismatch_count),
    .first_dut(first_dut), .first_gold(first_gold),
    .error(error), .overflow(overflow), .timeout(timeout), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    dut_valid = 1'b0;
    gold_valid = 1'b0;
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0;
    dut_valid = 1'b0; gold_valid = 1'b0; dut_data = '0; gold_data = '0;
    #2;
    checks++; if (match_count !== 16'd0) begin errors++; $display("FAIL reset_match got %0d exp 0", match_count); end
    checks++; if (mismatch_count !== 16'd0) begin errors++; $display("FAIL reset_mismatch got %0d exp 0", mismatch_count); end
    checks++; if (first_dut !== 32'd0 || first_gold !== 32'd0) begin errors++; $display("FAIL reset_first got %0d/%0d exp 0/0", first_dut, first_gold); end
    checks++; if ({error, overflow, timeout, halted} !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b exp 0000", {error, overflow, timeout, halted}); end
    #10 rst_n = 1'b1;
    step();
    checks++; if ({error, halted, match_count} !== 18'd0) begin errors++; $display("FAIL reset_idle got %0h exp 0", {error, halted, match_count}); end
  endtask

  task automatic test_lockstep();
    int v[6] = '{1, 1, 2, 3, 5, 8};
    do_clear();
    for (int i = 0; i < 6; i++) begin
      dut_valid = 1'b1; gold_valid = 1'b1; dut_data = v[i]; gold_data = v[i];
      step();
    end
    dut_valid = 1'b0; gold_valid = 1'b0;
    checks++; if (match_count !== 16'd5) begin errors++; $display("FAIL lock_latency got %0d exp 5", match_count); end
    step();
    checks++; if (match_count !== 16'd6) begin errors++; $display("FAIL lock_match got %0d exp 6", match_count); end
    checks++; if (mismatch_count !== 16'd0 || error !== 1'b0) begin errors++; $display("FAIL lock_clean got mm=%0d err=%b exp 0/0", mismatch_count, error); end
  endtask

  task automatic test_skew();
    int v[4] = '{1, 1, 2, 3};
    logic [3:0] occ;
    int peak = 0;
    do_clear();
    for (int c = 0; c < 10; c++) begin
      gold_valid = (c < 4);
      gold_data  = (c < 4) ? v[c] : 0;
      dut_valid  = (c >= 5 && c < 9);
      dut_data   = (c >= 5 && c < 9) ? v[c-5] : 0;
      step();
      occ = dut.u_gold_fifo.wptr - dut.u_gold_fifo.rptr;
      if (int'(occ) > peak) peak = int'(occ);
    end
    dut_valid = 1'b0; gold_valid = 1'b0;
    checks++; if (match_count !== 16'd4) begin errors++; $display("FAIL skew_match got %0d exp 4", match_count); end
    checks++; if (timeout !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL skew_flags got tmo=%b halt=%b exp 0/0", timeout, halted); end
    checks++; if (peak != 4) begin errors++; $display("FAIL skew_peak got %0d exp 4", peak); end
  endtask

  task automatic test_mismatch();
    int d[3] = '{5, 8, 14};
    int g[3] = '{5, 8, 13};
    do_clear();
    for (int i = 0; i < 3; i++) begin
      dut_valid = 1'b1; gold_valid = 1'b1; dut_data = d[i]; gold_data = g[i];
      step();
    end
    dut_valid = 1'b0; gold_valid = 1'b0;
    step();
    checks++; if (match_count !== 16'd2 || mismatch_count !== 16'd1) begin errors++; $display("FAIL mis_counts got %0d/%0d exp 2/1", match_count, mismatch_count); end
    checks++; if (first_dut !== 32'd14 || first_gold !== 32'd13) begin errors++; $display("FAIL mis_first got %0d/%0d exp 14/13", first_dut, first_gold); end
    checks++; if (error !== 1'b1 || halted !== 1'b1) begin errors++; $display("FAIL mis_halt got err=%b halt=%b exp 1/1", error, halted); end
    for (int i = 0; i < 4; i++) begin
      dut_valid = 1'b1; gold_valid = 1'b1; dut_data = 32'd20 + i; gold_data = 32'd30 + i;
      step();
    end
    dut_valid = 1'b0; gold_valid = 1'b0;
    step();
    checks++; if (match_count !== 16'd2 || mismatch_count !== 16'd1) begin errors++; $display("FAIL mis_hold_counts got %0d/%0d exp 2/1", match_count, mismatch_count); end
    checks++; if (first_dut !== 32'd14 || first_gold !== 32'd13 || halted !== 1'b1) begin errors++; $display("FAIL mis_hold_first got %0d/%0d halt=%b exp 14/13/1", first_dut, first_gold, halted); end
  endtask

  task automatic test_overflow();
    do_clear();
    for (int i = 0; i < 8; i++) begin
      gold_valid = 1'b1; gold_data = 32'd100 + i;
      step();
    end
    checks++; if (overflow !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL ovf_early got ovf=%b halt=%b exp 0/0", overflow, halted); end
    gold_data = 32'd200;
    step();
    gold_valid = 1'b0;
    checks++; if (overflow !== 1'b1 || error !== 1'b1) begin errors++; $display("FAIL ovf_set got ovf=%b err=%b exp 1/1", overflow, error); end
    step();
    checks++; if (halted !== 1'b1 || timeout !== 1'b0) begin errors++; $display("FAIL ovf_halt got halt=%b tmo=%b exp 1/0", halted, timeout); end
  endtask

  task automatic test_timeout();
    do_clear();
    dut_valid = 1'b1; dut_data = 32'd42;
    step();
    dut_valid = 1'b0;
    repeat (63) step();
    checks++; if (timeout !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL tmo_early got tmo=%b halt=%b exp 0/0", timeout, halted); end
    step();
    checks++; if (timeout !== 1'b1 || error !== 1'b1 || overflow !== 1'b0) begin errors++; $display("FAIL tmo_set got tmo=%b err=%b ovf=%b exp 1/1/0", timeout, error, overflow); end
    step();
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL tmo_halt got %b exp 1", halted); end
    do_clear();
    checks++; if ({error, overflow, timeout, halted} !== 4'b0000) begin errors++; $display("FAIL clear_flags got %b exp 0000", {error, overflow, timeout, halted}); end
    checks++; if (match_count !== 16'd0 || mismatch_count !== 16'd0 || first_dut !== 32'd0 || first_gold !== 32'd0) begin errors++; $display("FAIL clear_values got %0d/%0d/%0d/%0d exp 0/0/0/0", match_count, mismatch_count, first_dut, first_gold); end
  endtask

  task automatic test_reset_mid_burst();
    logic [3:0] occ;
    do_clear();
    dut_valid = 1'b1; gold_valid = 1'b1; dut_data = 32'd4; gold_data = 32'd4;
    step();
    dut_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      gold_data = i;
      step();
    end
    gold_valid = 1'b0;
    checks++; if (match_count !== 16'd1) begin errors++; $display("FAIL rst_pre got %0d exp 1", match_count); end
    #2 rst_n = 1'b0;
    #1;
    occ = dut.u_gold_fifo.wptr - dut.u_gold_fifo.rptr;
    checks++; if (match_count !== 16'd0 || occ !== 4'd0) begin errors++; $display("FAIL rst_async got cnt=%0d occ=%0d exp 0/0", match_count, occ); end
    #2 rst_n = 1'b1;
    step();
    dut_valid = 1'b1; gold_valid = 1'b1; dut_data = 32'd7; gold_data = 32'd7;
    step();
    dut_valid = 1'b0; gold_valid = 1'b0;
    step();
    checks++; if (match_count !== 16'd1 || mismatch_count !== 16'd0 || error !== 1'b0) begin errors++; $display("FAIL rst_after got %0d/%0d err=%b exp 1/0/0", match_count, mismatch_count, error); end
  endtask

  initial begin
    test_reset();
    test_lockstep();
    test_skew();
    test_mismatch();
    test_overflow();
    test_timeout();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
